// File: rtl/eeprom_serial_ctrl_if.sv
// Cartridge-bus side of the EEPROM serial controller: single-bit halfword
// write/read strobes from the bus decoder and the read response back to it.
interface eeprom_serial_ctrl_if;
    logic bus_wr;
    logic bus_wdata;
    logic bus_rd;
    logic bus_rdata;
    logic bus_rvalid;

    modport master (
        output bus_wr,
        output bus_wdata,
        output bus_rd,
        input  bus_rdata,
        input  bus_rvalid
    );

    modport slave (
        input  bus_wr,
        input  bus_wdata,
        input  bus_rd,
        output bus_rdata,
        output bus_rvalid
    );
endinterface

// File: rtl/eeprom_serial_ctrl.sv
// GBA cartridge EEPROM serial protocol engine. Commands, addresses and data
// arrive one bit per bus halfword write; the 64-bit block lives in the 1-bit
// port A of the save RAM. Reads answer two cycles after the strobe.
module eeprom_serial_ctrl #(
    parameter int WRITE_BUSY_CYCLES = 4096,
    parameter int CNT_W             = 13
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 size_8k,
    eeprom_serial_ctrl_if.slave  bus,
    output logic [15:0]          ram_ad,
    output logic                 ram_din,
    output logic                 ram_ce,
    output logic                 ram_we,
    input  logic                 ram_dout,
    output logic                 dirty,
    input  logic                 dirty_clr
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RSTOP,
        S_WSTOP, S_RDUMMY, S_RDATA, S_COMMIT, S_WBUSY
    } state_t;

    state_t           state_q, state_d;
    logic             is_read_q, is_read_d;
    logic             size_q, size_d;
    // Shared counter: bits left in a field, dummy reads left, or bit index n.
    logic [6:0]       cnt_q, cnt_d;
    logic [9:0]       addr_q, addr_d;
    logic [63:0]      data_q, data_d;
    logic [CNT_W-1:0] busy_q, busy_d;

    logic [15:0]      ram_ad_d;
    logic             ram_din_d, ram_ce_d, ram_we_d;
    logic             dirty_d;

    logic             vld_p1, vld_p1_d;
    logic             rdata_p1, rdata_p1_d;
    logic             from_ram_p1, from_ram_p1_d;
    logic             vld_p2, rdata_p2, from_ram_p2;

    logic             wr_take, rd_take;
    logic [9:0]       blk;

    // A write strobe wins over a simultaneous read strobe.
    assign wr_take = bus.bus_wr;
    assign rd_take = bus.bus_rd & ~bus.bus_wr;

    // Only the low address bits the device size allows select the block.
    assign blk = size_q ? addr_q : {4'b0000, addr_q[5:0]};

    // Bit n of a block, sent MSB first, lands so each byte reads MSB-first on port B.
    function automatic logic [15:0] bit_addr(input logic [9:0] b, input logic [5:0] n);
        return {b, n[5:3], ~n[2:0]};
    endfunction

    // Next-state, counters, RAM port and read-response selection.
    always_comb begin
        state_d       = state_q;
        is_read_d     = is_read_q;
        size_d        = size_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        data_d        = data_q;
        busy_d        = busy_q;
        ram_ad_d      = ram_ad;
        ram_din_d     = ram_din;
        ram_ce_d      = 1'b0;
        ram_we_d      = 1'b0;
        dirty_d       = dirty_clr ? 1'b0 : dirty;
        vld_p1_d      = 1'b0;
        rdata_p1_d    = 1'b0;
        from_ram_p1_d = 1'b0;

        case (state_q)
            S_IDLE, S_RDUMMY, S_RDATA: begin
                if (wr_take) begin
                    // A write here starts (or aborts into) a new command.
                    if (bus.bus_wdata) begin
                        state_d = S_CMD;
                        size_d  = size_8k;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (rd_take) begin
                    vld_p1_d = 1'b1;
                    if (state_q == S_IDLE) begin
                        rdata_p1_d = 1'b1;
                    end else if (state_q == S_RDUMMY) begin
                        if (cnt_q == 7'd1) begin
                            state_d = S_RDATA;
                            cnt_d   = 7'd0;
                        end else begin
                            cnt_d = cnt_q - 7'd1;
                        end
                    end else begin
                        ram_ce_d      = 1'b1;
                        ram_ad_d      = bit_addr(blk, cnt_q[5:0]);
                        from_ram_p1_d = 1'b1;
                        if (cnt_q == 7'd63) begin
                            state_d = S_IDLE;
                            cnt_d   = 7'd0;
                        end else begin
                            cnt_d = cnt_q + 7'd1;
                        end
                    end
                end
            end
            S_CMD, S_ADDR, S_WDATA, S_RSTOP, S_WSTOP: begin
                if (wr_take) begin
                    case (state_q)
                        S_CMD: begin
                            is_read_d = bus.bus_wdata;
                            cnt_d     = size_q ? 7'd14 : 7'd6;
                            state_d   = S_ADDR;
                        end
                        S_ADDR: begin
                            addr_d = {addr_q[8:0], bus.bus_wdata};
                            if (cnt_q == 7'd1) begin
                                if (is_read_q) begin
                                    state_d = S_RSTOP;
                                end else begin
                                    state_d = S_WDATA;
                                    cnt_d   = 7'd64;
                                end
                            end else begin
                                cnt_d = cnt_q - 7'd1;
                            end
                        end
                        S_WDATA: begin
                            data_d = {data_q[62:0], bus.bus_wdata};
                            if (cnt_q == 7'd1) begin
                                state_d = S_WSTOP;
                                cnt_d   = 7'd0;
                            end else begin
                                cnt_d = cnt_q - 7'd1;
                            end
                        end
                        S_RSTOP: begin
                            state_d = S_RDUMMY;
                            cnt_d   = 7'd4;
                        end
                        S_WSTOP: begin
                            state_d = S_COMMIT;
                            cnt_d   = 7'd0;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else if (rd_take) begin
                    vld_p1_d   = 1'b1;
                    rdata_p1_d = 1'b1;
                end
            end
            S_COMMIT: begin
                ram_ce_d  = 1'b1;
                ram_we_d  = 1'b1;
                ram_ad_d  = bit_addr(blk, cnt_q[5:0]);
                ram_din_d = data_q[~cnt_q[5:0]];
                if (cnt_q == 7'd63) begin
                    state_d = S_WBUSY;
                    cnt_d   = 7'd0;
                    dirty_d = 1'b1;
                    busy_d  = CNT_W'(WRITE_BUSY_CYCLES);
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
                if (rd_take) vld_p1_d = 1'b1;
            end
            S_WBUSY: begin
                if (busy_q == '0) state_d = S_IDLE;
                else              busy_d  = busy_q - CNT_W'(1);
                if (rd_take) vld_p1_d = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; an asynchronous reset abandons any command in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Command datapath, RAM port A and the two-stage read response.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_read_q   <= 1'b0;
            size_q      <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            busy_q      <= '0;
            ram_ad      <= '0;
            ram_din     <= 1'b0;
            ram_ce      <= 1'b0;
            ram_we      <= 1'b0;
            dirty       <= 1'b0;
            vld_p1      <= 1'b0;
            rdata_p1    <= 1'b0;
            from_ram_p1 <= 1'b0;
            vld_p2      <= 1'b0;
            rdata_p2    <= 1'b0;
            from_ram_p2 <= 1'b0;
        end else begin
            is_read_q   <= is_read_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            ram_ad      <= ram_ad_d;
            ram_din     <= ram_din_d;
            ram_ce      <= ram_ce_d;
            ram_we      <= ram_we_d;
            dirty       <= dirty_d;
            // stage 1: strobe accepted, RAM access issued
            vld_p1      <= vld_p1_d;
            rdata_p1    <= rdata_p1_d;
            from_ram_p1 <= from_ram_p1_d;
            // stage 2: response presented, RAM data now valid
            vld_p2      <= vld_p1;
            rdata_p2    <= rdata_p1;
            from_ram_p2 <= from_ram_p1;
        end
    end

    assign bus.bus_rvalid = vld_p2;
    assign bus.bus_rdata  = vld_p2 & (from_ram_p2 ? ram_dout : rdata_p2);

endmodule

// File: tb/tb_eeprom_serial_ctrl.sv
// Directed bench for eeprom_serial_ctrl with a behavioural 64 Kbit port-A RAM.
module tb_eeprom_serial_ctrl;
    localparam int WBC = 4096;
    localparam int CW  = 13;

    logic        clk = 1'b0;
    logic        resetn;
    logic        size_8k;
    logic [15:0] ram_ad;
    logic        ram_din, ram_ce, ram_we, ram_dout, dirty, dirty_clr;

    eeprom_serial_ctrl_if bus ();

    eeprom_serial_ctrl #(.WRITE_BUSY_CYCLES(WBC), .CNT_W(CW)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .size_8k   (size_8k),
        .bus       (bus),
        .ram_ad    (ram_ad),
        .ram_din   (ram_din),
        .ram_ce    (ram_ce),
        .ram_we    (ram_we),
        .ram_dout  (ram_dout),
        .dirty     (dirty),
        .dirty_clr (dirty_clr)
    );

    always #5 clk = ~clk;

    // Port A RAM model: synchronous write, read data valid the cycle after ce.
    logic mem [65536];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_ad] <= ram_din;
            else        ram_dout    <= mem[ram_ad];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Commit observer: write cycles seen and how many left the expected block.
    logic [9:0] mon_blk = 10'd0;
    int we_cycles = 0;
    int bad_ad = 0;
    always @(negedge clk) begin
        if (ram_ce && ram_we) begin
            we_cycles <= we_cycles + 1;
            if (ram_ad[15:6] != mon_blk) bad_ad <= bad_ad + 1;
        end
    end

    int checks = 0;
    int failures = 0;
    int last_wr_cyc = 0;

    localparam logic [63:0] D8K = 64'hDEADBEEF01234567;
    localparam logic [63:0] P512 = 64'hFFFF0000FFFF0000;
    localparam logic [63:0] PBSY = 64'h5A5AC3C30FF01234;

    function automatic logic [15:0] map_bit(input logic [9:0] b, input int n);
        logic [5:0] nn;
        nn = n[5:0];
        return {b, nn[5:3], ~nn[2:0]};
    endfunction

    task automatic strobe_wr(input logic b);
        @(negedge clk);
        bus.bus_wr = 1'b1;
        bus.bus_wdata = b;
        last_wr_cyc = cyc;
        @(negedge clk);
        bus.bus_wr = 1'b0;
        bus.bus_wdata = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic strobe_rd(output logic val, output logic v1, output logic v2, output int at);
        @(negedge clk);
        bus.bus_rd = 1'b1;
        at = cyc;
        @(negedge clk);
        bus.bus_rd = 1'b0;
        v1 = bus.bus_rvalid;
        @(negedge clk);
        v2 = bus.bus_rvalid;
        val = bus.bus_rdata;
        @(negedge clk);
    endtask

    task automatic send_addr(input logic sz, input logic [13:0] a);
        for (int i = (sz ? 13 : 5); i >= 0; i--) strobe_wr(a[i]);
    endtask

    task automatic send_write(input logic sz, input logic [13:0] a, input logic [63:0] d);
        size_8k = sz;
        strobe_wr(1'b1);
        strobe_wr(1'b0);
        send_addr(sz, a);
        for (int i = 63; i >= 0; i--) strobe_wr(d[i]);
        strobe_wr(1'b0);
    endtask

    task automatic send_read_cmd(input logic sz, input logic [13:0] a);
        size_8k = sz;
        strobe_wr(1'b1);
        strobe_wr(1'b1);
        send_addr(sz, a);
        strobe_wr(1'b1);
    endtask

    task automatic read_block(output logic [63:0] d, output int dummy_bad, output int vld_bad);
        logic v, a1, a2;
        int t;
        d = '0;
        dummy_bad = 0;
        vld_bad = 0;
        for (int i = 0; i < 4; i++) begin
            strobe_rd(v, a1, a2, t);
            if (v !== 1'b0 || a1 !== 1'b0 || a2 !== 1'b1) dummy_bad++;
        end
        for (int i = 0; i < 64; i++) begin
            strobe_rd(v, a1, a2, t);
            d = {d[62:0], v};
            if (a1 !== 1'b0 || a2 !== 1'b1) vld_bad++;
        end
    endtask

    // Polls reads until one returns 1; reports its distance from ref_cyc (-1 on timeout).
    task automatic wait_ready(input int ref_cyc, output int first);
        logic v, a1, a2;
        int t;
        first = -1;
        for (int i = 0; i < 3000; i++) begin
            strobe_rd(v, a1, a2, t);
            if (a2 === 1'b1 && v === 1'b1) begin
                first = t - ref_cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic v, a1, a2;
        int t;
        resetn = 1'b0;
        size_8k = 1'b1;
        dirty_clr = 1'b0;
        bus.bus_wr = 1'b0;
        bus.bus_wdata = 1'b0;
        bus.bus_rd = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.bus_rdata, bus.bus_rvalid, ram_ce, ram_we, ram_din, dirty, ram_ad} !== 22'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {bus.bus_rdata, bus.bus_rvalid, ram_ce, ram_we, ram_din, dirty, ram_ad});
        end
        resetn = 1'b1;
        strobe_rd(v, a1, a2, t);
        checks++;
        if ({a2, v} !== 2'b11) begin
            failures++;
            $display("FAIL reset_idle_read got=%b exp=11", {a2, v});
        end
    endtask

    task automatic test_read_latency();
        logic v, a1, a2, s1, s2, s3;
        int t;
        strobe_rd(v, a1, a2, t);
        checks++;
        if ({a1, a2, v} !== 3'b011) begin
            failures++;
            $display("FAIL lat_rvalid got=%b exp=011", {a1, a2, v});
        end
        @(negedge clk);
        bus.bus_rd = 1'b1;
        bus.bus_wr = 1'b1;
        bus.bus_wdata = 1'b0;
        @(negedge clk);
        bus.bus_rd = 1'b0;
        bus.bus_wr = 1'b0;
        s1 = bus.bus_rvalid;
        @(negedge clk);
        s2 = bus.bus_rvalid;
        @(negedge clk);
        s3 = bus.bus_rvalid;
        checks++;
        if ({s1, s2, s3} !== 3'b000) begin
            failures++;
            $display("FAIL lat_rd_wr_together got=%b exp=000", {s1, s2, s3});
        end
        strobe_rd(v, a1, a2, t);
        checks++;
        if ({a2, v} !== 2'b11) begin
            failures++;
            $display("FAIL lat_after_zero_wr got=%b exp=11", {a2, v});
        end
    endtask

    task automatic test_write_read_8k();
        int first, w0, b0, db, vb, stop_cyc;
        logic [63:0] got;
        logic [7:0] b40;
        mon_blk = 10'd5;
        w0 = we_cycles;
        b0 = bad_ad;
        send_write(1'b1, 14'h3C05, D8K);
        stop_cyc = last_wr_cyc;
        wait_ready(stop_cyc, first);
        checks++;
        if (first < 64 + WBC || first > 64 + WBC + 6) begin
            failures++;
            $display("FAIL w8k_busy_len got=%0d exp=%0d..%0d", first, 64 + WBC, 64 + WBC + 6);
        end
        checks++;
        if (we_cycles - w0 != 64 || bad_ad - b0 != 0) begin
            failures++;
            $display("FAIL w8k_commit got=%0d/%0d exp=64/0", we_cycles - w0, bad_ad - b0);
        end
        checks++;
        if (dirty !== 1'b1) begin
            failures++;
            $display("FAIL w8k_dirty_set got=%b exp=1", dirty);
        end
        @(negedge clk);
        dirty_clr = 1'b1;
        @(negedge clk);
        dirty_clr = 1'b0;
        checks++;
        if (dirty !== 1'b0) begin
            failures++;
            $display("FAIL w8k_dirty_clr got=%b exp=0", dirty);
        end
        for (int i = 0; i < 8; i++) b40[i] = mem[16'(320 + i)];
        checks++;
        if (b40 !== 8'hDE) begin
            failures++;
            $display("FAIL w8k_byte40 got=%h exp=de", b40);
        end
        send_read_cmd(1'b1, 14'h0005);
        read_block(got, db, vb);
        checks++;
        if (got !== D8K) begin
            failures++;
            $display("FAIL r8k_data got=%h exp=%h", got, D8K);
        end
        checks++;
        if (db != 0 || vb != 0) begin
            failures++;
            $display("FAIL r8k_dummy_valid got=%0d/%0d exp=0/0", db, vb);
        end
    endtask

    task automatic test_busy_ignored_writes();
        int first, db, vb, stop_cyc, bad;
        logic [63:0] got;
        mon_blk = 10'd2;
        send_write(1'b1, 14'h0002, PBSY);
        stop_cyc = last_wr_cyc;
        repeat (200) @(negedge clk);
        for (int i = 0; i < 20; i++) strobe_wr((i % 2) == 0);
        wait_ready(stop_cyc, first);
        checks++;
        if (first < 64 + WBC || first > 64 + WBC + 6) begin
            failures++;
            $display("FAIL busy_len got=%0d exp=%0d..%0d", first, 64 + WBC, 64 + WBC + 6);
        end
        bad = 0;
        for (int n = 0; n < 64; n++) if (mem[map_bit(10'd2, n)] !== PBSY[63 - n]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL busy_ram_intact got=%0d exp=0 bad bits", bad);
        end
        send_read_cmd(1'b1, 14'h0002);
        read_block(got, db, vb);
        checks++;
        if (got !== PBSY || db != 0 || vb != 0) begin
            failures++;
            $display("FAIL busy_readback got=%h exp=%h", got, PBSY);
        end
    endtask

    task automatic test_512();
        int first, w0, b0, db, vb, stop_cyc;
        logic [63:0] got;
        mon_blk = 10'h03F;
        w0 = we_cycles;
        b0 = bad_ad;
        send_write(1'b0, 14'h003F, P512);
        stop_cyc = last_wr_cyc;
        wait_ready(stop_cyc, first);
        checks++;
        if (we_cycles - w0 != 64 || bad_ad - b0 != 0) begin
            failures++;
            $display("FAIL w512_commit_addr got=%0d/%0d exp=64/0", we_cycles - w0, bad_ad - b0);
        end
        checks++;
        if (dirty !== 1'b1) begin
            failures++;
            $display("FAIL w512_dirty got=%b exp=1", dirty);
        end
        send_read_cmd(1'b0, 14'h003F);
        read_block(got, db, vb);
        checks++;
        if (got !== P512 || db != 0 || vb != 0) begin
            failures++;
            $display("FAIL r512_data got=%h exp=%h", got, P512);
        end
    endtask

    task automatic test_abort();
        logic v, a1, a2;
        logic [9:0] got10;
        logic [63:0] got;
        int t, db, vb;
        send_read_cmd(1'b1, 14'h0005);
        for (int i = 0; i < 4; i++) strobe_rd(v, a1, a2, t);
        got10 = '0;
        for (int i = 0; i < 10; i++) begin
            strobe_rd(v, a1, a2, t);
            got10 = {got10[8:0], v};
        end
        checks++;
        if (got10 !== D8K[63:54]) begin
            failures++;
            $display("FAIL abort_first10 got=%h exp=%h", got10, D8K[63:54]);
        end
        send_read_cmd(1'b1, 14'h003F);
        read_block(got, db, vb);
        checks++;
        if (got !== P512 || db != 0 || vb != 0) begin
            failures++;
            $display("FAIL abort_new_block got=%h exp=%h", got, P512);
        end
    endtask

    task automatic test_reset_mid_commit();
        logic [63:0] a_pat, b_pat;
        logic seen, hit, v, a1, a2;
        int first, stop_cyc, bad_lo, bad_hi, t;
        a_pat = 64'h0123456789ABCDEF;
        b_pat = ~a_pat;
        mon_blk = 10'd7;
        dirty_clr = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (dirty !== 1'b0) begin
            failures++;
            $display("FAIL rst_pre_clr got=%b exp=0", dirty);
        end
        send_write(1'b1, 14'h0007, a_pat);
        stop_cyc = last_wr_cyc;
        seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (dirty === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        dirty_clr = 1'b0;
        checks++;
        if (seen !== 1'b1) begin
            failures++;
            $display("FAIL dirty_set_priority got=%b exp=1", seen);
        end
        wait_ready(stop_cyc, first);
        send_write(1'b1, 14'h0007, b_pat);
        hit = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (ram_ce && ram_we && ram_ad == map_bit(10'd7, 20)) begin
                hit = 1'b1;
                break;
            end
        end
        resetn = 1'b0;
        checks++;
        if (hit !== 1'b1) begin
            failures++;
            $display("FAIL rst_reach_n20 got=%b exp=1", hit);
        end
        #1;
        checks++;
        if ({bus.bus_rdata, bus.bus_rvalid, ram_ce, ram_we, ram_din, dirty, ram_ad} !== 22'd0) begin
            failures++;
            $display("FAIL rst_mid_outputs got=%h exp=0",
                     {bus.bus_rdata, bus.bus_rvalid, ram_ce, ram_we, ram_din, dirty, ram_ad});
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        bad_lo = 0;
        bad_hi = 0;
        for (int n = 0; n < 20; n++) if (mem[map_bit(10'd7, n)] !== b_pat[63 - n]) bad_lo++;
        for (int n = 20; n < 64; n++) if (mem[map_bit(10'd7, n)] !== a_pat[63 - n]) bad_hi++;
        checks++;
        if (bad_lo != 0) begin
            failures++;
            $display("FAIL rst_bits_written got=%0d exp=0 bad bits", bad_lo);
        end
        checks++;
        if (bad_hi != 0) begin
            failures++;
            $display("FAIL rst_bits_kept got=%0d exp=0 bad bits", bad_hi);
        end
        strobe_rd(v, a1, a2, t);
        checks++;
        if ({a2, v, dirty} !== 3'b110) begin
            failures++;
            $display("FAIL rst_next_read got=%b exp=110", {a2, v, dirty});
        end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_read_8k();
        test_busy_ignored_writes();
        test_512();
        test_abort();
        test_reset_mid_commit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
